// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4
// Four-requester round-robin arbiter for one shared combinational resource.
// Priority rotates past each owner when it is released. A grant is
// force-released after HOLD_MAX consecutive cycles. One dead cycle always
// separates two grants.
//
// Parameters:
//   HOLD_MAX  maximum consecutive cycles a single grant may last (1..255)
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   req[3:0]  request lines, one per client
//   grant     registered one-hot grant, or all-zero
//   grant_id  registered index of the owner; meaningful only while busy=1
//   busy      registered, high while any grant is active (equals |grant)
//   timeout   registered single-cycle pulse when HOLD_MAX forces a release
module rr_arbiter_4 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_e;

  state_e     state_q,    state_d;
  logic [1:0] ptr_q,      ptr_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [3:0] grant_q,    grant_d;
  logic [1:0] grant_id_q, grant_id_d;
  logic       busy_q,     busy_d;
  logic       timeout_q,  timeout_d;

  // Rotating-priority search result
  logic       pick_valid;
  logic [1:0] pick_id;
  logic [1:0] cand;

  // Owner status while GRANTED
  logic owner_req;
  logic hold_at_max;
  logic release_now;

  // First requester found when searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  // The 2-bit add wraps naturally.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_id    = cand;
      end
    end
  end

  always_comb begin
    owner_req   = req[grant_id_q];
    hold_at_max = (hold_cnt_q == 8'(HOLD_MAX));
    // A drop on the owner's req wins over the hold limit. This makes a
    // simultaneous drop at the limit a normal release.
    release_now = !owner_req || hold_at_max;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_valid)  state_d = GRANTED;
      GRANTED: if (release_now) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath logic. It produces the values the registered outputs
  // take on the next edge.
  always_comb begin
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d    = 4'b0001 << pick_id;
          grant_id_d = pick_id;
          busy_d     = 1'b1;
          hold_cnt_d = 8'd1;
        end else begin
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      GRANTED: begin
        if (release_now) begin
          grant_d    = '0;
          busy_d     = 1'b0;
          hold_cnt_d = '0;
          ptr_d      = grant_id_q + 2'd1;
          // The release is forced only when the owner still wants the resource.
          timeout_d  = owner_req;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;

  a_grant_onehot0: assert property (@(posedge clk) $onehot0(grant_q));
  a_busy_matches:  assert property (@(posedge clk) busy_q == (|grant_q));
  a_timeout_pulse: assert property (@(posedge clk) disable iff (rst)
                                    timeout_q |=> !timeout_q);

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Testbench for rr_arbiter_4. It runs three instances (HOLD_MAX = 8, 4, 1)
// against a behavioural model. The model tracks the owner, the cycles held
// and the next-priority client.
module tb_rr_arbiter_4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] rq  [3];
  logic [3:0] g   [3];
  logic [1:0] gid [3];
  logic       bsy [3];
  logic       tmo [3];

  int unsigned checks = 0;
  int unsigned errors = 0;

  int hm      [3] = '{8, 4, 1};
  int m_owner [3] = '{-1, -1, -1};
  int m_ptr   [3] = '{0, 0, 0};
  int m_held  [3] = '{0, 0, 0};
  int m_to    [3] = '{0, 0, 0};

  rr_arbiter_4 #(.HOLD_MAX(8)) u_dut8 (
    .clk(clk), .rst(rst), .req(rq[0]), .grant(g[0]), .grant_id(gid[0]),
    .busy(bsy[0]), .timeout(tmo[0]));
  rr_arbiter_4 #(.HOLD_MAX(4)) u_dut4 (
    .clk(clk), .rst(rst), .req(rq[1]), .grant(g[1]), .grant_id(gid[1]),
    .busy(bsy[1]), .timeout(tmo[1]));
  rr_arbiter_4 #(.HOLD_MAX(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(rq[2]), .grant(g[2]), .grant_id(gid[2]),
    .busy(bsy[2]), .timeout(tmo[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // The model advances on the same edge as the DUTs, using the applied inputs.
  task automatic model_step();
    int idx;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_owner[i] = -1; m_ptr[i] = 0; m_held[i] = 0; m_to[i] = 0;
      end else if (m_owner[i] < 0) begin
        m_to[i] = 0;
        for (int k = 0; k < 4; k++) begin
          idx = (m_ptr[i] + k) % 4;
          if (m_owner[i] < 0 && rq[i][idx]) begin
            m_owner[i] = idx;
            m_held[i]  = 1;
          end
        end
      end else if (!rq[i][m_owner[i]]) begin
        m_ptr[i] = (m_owner[i] + 1) % 4; m_owner[i] = -1; m_to[i] = 0;
      end else if (m_held[i] == hm[i]) begin
        m_ptr[i] = (m_owner[i] + 1) % 4; m_owner[i] = -1; m_to[i] = 1;
      end else begin
        m_held[i]++;
        m_to[i] = 0;
      end
    end
  endtask

  task automatic compare_all();
    int expg;
    for (int i = 0; i < 3; i++) begin
      expg = (m_owner[i] >= 0) ? (1 << m_owner[i]) : 0;
      check($sformatf("grant%0d", i), 32'(g[i]), 32'(expg));
      check($sformatf("busy%0d", i), 32'(bsy[i]), 32'(m_owner[i] >= 0));
      check($sformatf("timeout%0d", i), 32'(tmo[i]), 32'(m_to[i]));
      if (m_owner[i] >= 0)
        check($sformatf("grant_id%0d", i), 32'(gid[i]), 32'(m_owner[i]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int order[$];
    int exp_order[5] = '{1, 2, 4, 8, 1};
    logic [3:0] mask;

    // Reset held for two cycles with all requests high
    rst = 1'b1;
    for (int i = 0; i < 3; i++) rq[i] = 4'hF;
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
    check("first_grant", 32'(g[0]), 32'h1);
    for (int i = 0; i < 3; i++) rq[i] = 4'h0;
    repeat (3) cycle();

    // A single client holds the grant for three cycles, then releases
    rq[0] = 4'b0100;
    repeat (3) cycle();
    check("single_gid", 32'(gid[0]), 32'd2);
    rq[0] = 4'b0000;
    repeat (3) cycle();

    // Rotation: each owner drops its request after two granted cycles
    do_reset();
    rq[0] = 4'hF;
    for (int c = 0; c < 40 && order.size() < 5; c++) begin
      cycle();
      if (m_owner[0] >= 0 && m_held[0] == 1) order.push_back(int'(g[0]));
      if (m_owner[0] >= 0 && m_held[0] == 2) rq[0] = 4'hF & ~(4'b0001 << m_owner[0]);
      else rq[0] = 4'hF;
    end
    check("rot_count", 32'(order.size()), 32'd5);
    for (int k = 0; k < 5 && k < order.size(); k++)
      check($sformatf("rot_order%0d", k), 32'(order[k]), 32'(exp_order[k]));
    rq[0] = 4'h0;
    repeat (3) cycle();

    // A held request is force-released after eight cycles
    do_reset();
    rq[0] = 4'b0010;
    repeat (8) cycle();
    check("to8_last", 32'(g[0]), 32'h2);
    cycle();
    check("to8_dead", 32'(g[0]), 32'h0);
    check("to8_pulse", 32'(tmo[0]), 32'h1);
    cycle();
    check("to8_regrant", 32'(g[0]), 32'h2);
    check("to8_pulse_end", 32'(tmo[0]), 32'h0);
    repeat (12) cycle();
    rq[0] = 4'h0;
    repeat (2) cycle();

    // Fairness under timeout on the HOLD_MAX=4 instance
    do_reset();
    rq[1] = 4'b0011;
    repeat (4) cycle();
    check("fair_g0", 32'(g[1]), 32'h1);
    cycle();
    check("fair_to0", 32'(tmo[1]), 32'h1);
    repeat (4) cycle();
    check("fair_g1", 32'(g[1]), 32'h2);
    cycle();
    check("fair_to1", 32'(tmo[1]), 32'h1);
    cycle();
    check("fair_g0_again", 32'(g[1]), 32'h1);
    repeat (6) cycle();
    rq[1] = 4'h0;
    repeat (2) cycle();

    // Reset asserted during the third granted cycle
    do_reset();
    rq[0] = 4'b1000;
    repeat (3) cycle();
    check("midrst_pre", 32'(g[0]), 32'h8);
    rst = 1'b1;
    cycle();
    check("midrst_drop", 32'(g[0]), 32'h0);
    rst = 1'b0;
    rq[0] = 4'b1001;
    cycle();
    check("midrst_after", 32'(g[0]), 32'h1);
    rq[0] = 4'h0;
    repeat (2) cycle();

    // The owner drops its request on the same edge the hold limit is reached
    rq[0] = 4'b0001;
    repeat (8) cycle();
    rq[0] = 4'b0000;
    cycle();
    check("simul_drop_to", 32'(tmo[0]), 32'h0);
    check("simul_drop_g", 32'(g[0]), 32'h0);
    repeat (2) cycle();

    // Randomised traffic with sticky requests and occasional resets
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        mask = '0;
        for (int b = 0; b < 4; b++)
          if ($urandom_range(7) == 0) mask[b] = 1'b1;
        rq[i] = rq[i] ^ mask;
      end
      rst = ($urandom_range(299) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
